// File: rtl/manchester_frame_encoder_pkg.sv
// Shared types and helpers for the Manchester frame encoder.
// Holds the FSM state encoding, the polarity constants and the half-bit level function.
package manchester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC_A = 2'd1,
    ST_SYNC_B = 2'd2,
    ST_DATA   = 2'd3
  } man_state_e;

  localparam logic MAN_IEEE   = 1'b0;
  localparam logic MAN_THOMAS = 1'b1;

  // IEEE sends ~bit in the first half and bit in the second; Thomas inverts both.
  function automatic logic man_half_level(input logic data_bit, input logic half,
                                          input logic polarity);
    return data_bit ^ ~half ^ polarity;
  endfunction

endpackage

// File: rtl/manchester_frame_encoder_period_counter.sv
// Free-running period counter that wraps to zero when it reaches a caller-chosen
// terminal value; shared by the preamble phases and the data half-bits.
module manchester_period_counter #(
  parameter int MAX_COUNT = 80,
  localparam int CNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1
) (
  input  logic             clk16x,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic [CNT_W-1:0] term_value,
  output logic             terminal
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign terminal = (count_q == term_value);

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (terminal) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk16x) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/manchester_frame_encoder.sv
// Serialises a valid/ready word stream into Manchester-coded frames: a two-phase
// sync preamble followed by back-to-back words until the word tagged s_last.
module manchester_frame_encoder
  import manchester_pkg::*;
#(
  parameter int   DATA_W         = 8,
  parameter int   HALF_BIT_LEN   = 40,
  parameter int   SYNC_HALF_BITS = 3,
  parameter logic POLARITY       = MAN_IEEE,
  parameter logic MSB_FIRST      = 1'b0,
  parameter logic IDLE_LEVEL     = 1'b0
) (
  input  logic              clk16x,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);

  localparam int SYNC_LEN = SYNC_HALF_BITS * HALF_BIT_LEN;
  localparam int CNT_MAX  = ((SYNC_HALF_BITS > 2) ? SYNC_HALF_BITS : 2) * HALF_BIT_LEN;
  localparam int CNT_W    = $clog2(CNT_MAX);
  localparam int BIT_W    = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] SYNC_TERM = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(HALF_BIT_LEN - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

  man_state_e        state_q, state_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              buf_last_q, buf_last_d;
  logic              buf_full_q, buf_full_d;
  logic [DATA_W-1:0] cur_data_q, cur_data_d;
  logic              cur_last_q, cur_last_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic              half_q, half_d;
  logic              tx_q, tx_d;
  logic              frame_done_q, frame_done_d;
  logic              underrun_q, underrun_d;

  logic              cnt_terminal;
  logic              cnt_clear;
  logic [CNT_W-1:0]  term_value;
  logic              accept;
  logic              half_end;
  logic              word_end;
  logic              sync_b_end;
  logic              reload;
  logic [DATA_W-1:0] tx_order;

  manchester_period_counter #(
    .MAX_COUNT(CNT_MAX)
  ) u_period (
    .clk16x    (clk16x),
    .reset     (reset),
    .clear     (cnt_clear),
    .load      (1'b0),
    .load_value('0),
    .term_value(term_value),
    .terminal  (cnt_terminal)
  );

  assign s_ready    = ~buf_full_q & ~reset;
  assign accept     = s_valid & s_ready;
  assign cnt_clear  = (state_q == ST_IDLE);
  assign term_value = (state_q == ST_DATA) ? HALF_TERM : SYNC_TERM;
  assign half_end   = (state_q == ST_DATA) & cnt_terminal;
  assign word_end   = half_end & half_q & (bit_idx_q == LAST_BIT);
  assign sync_b_end = (state_q == ST_SYNC_B) & cnt_terminal;
  assign reload     = sync_b_end | (word_end & ~cur_last_q & buf_full_q);

  // Reorder once so the bit index always counts in transmit order.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_order
    assign tx_order[gi] = MSB_FIRST ? cur_data_q[DATA_W-1-gi] : cur_data_q[gi];
  end

  always_ff @(posedge clk16x) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (buf_full_q) state_d = ST_SYNC_A;
      ST_SYNC_A: if (cnt_terminal) state_d = ST_SYNC_B;
      ST_SYNC_B: if (cnt_terminal) state_d = ST_DATA;
      ST_DATA:   if (word_end && (cur_last_q || !buf_full_q)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_d         = IDLE_LEVEL;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    case (state_q)
      ST_SYNC_A: tx_d = ~IDLE_LEVEL;
      ST_SYNC_B: tx_d = IDLE_LEVEL;
      ST_DATA: begin
        tx_d         = man_half_level(tx_order[bit_idx_q], half_q, POLARITY);
        frame_done_d = word_end & cur_last_q;
        underrun_d   = word_end & ~cur_last_q & ~buf_full_q;
      end
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  // Acceptance and reload never coincide: s_ready is low whenever the buffer is full.
  always_comb begin
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    buf_full_d = buf_full_q;
    cur_data_d = cur_data_q;
    cur_last_d = cur_last_q;
    bit_idx_d  = bit_idx_q;
    half_d     = half_q;
    if (accept) begin
      buf_data_d = s_data;
      buf_last_d = s_last;
      buf_full_d = 1'b1;
    end
    if (reload) begin
      cur_data_d = buf_data_q;
      cur_last_d = buf_last_q;
      buf_full_d = 1'b0;
    end
    if (state_q != ST_DATA) begin
      bit_idx_d = '0;
      half_d    = 1'b0;
    end else if (half_end) begin
      half_d = ~half_q;
      if (half_q) begin
        bit_idx_d = (bit_idx_q == LAST_BIT) ? '0 : bit_idx_q + BIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk16x) begin
    if (reset) begin
      buf_data_q   <= '0;
      buf_last_q   <= 1'b0;
      buf_full_q   <= 1'b0;
      cur_data_q   <= '0;
      cur_last_q   <= 1'b0;
      bit_idx_q    <= '0;
      half_q       <= 1'b0;
      tx_q         <= IDLE_LEVEL;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      buf_data_q   <= buf_data_d;
      buf_last_q   <= buf_last_d;
      buf_full_q   <= buf_full_d;
      cur_data_q   <= cur_data_d;
      cur_last_q   <= cur_last_d;
      bit_idx_q    <= bit_idx_d;
      half_q       <= half_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_manchester_frame_encoder.sv
// Directed bench for manchester_frame_encoder: default build plus a 12-bit
// Thomas / MSB-first / idle-high build, with hand-derived waveforms.
module tb_manchester_frame_encoder;

  logic        clk16x = 1'b0;
  logic        reset;
  logic        s_valid, s_last, s_ready, tx, busy, frame_done, underrun;
  logic [7:0]  s_data;
  logic        v2, l2, rdy2, tx2, busy2, fd2, un2;
  logic [11:0] d2;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int un_cnt = 0;
  int fd2_cnt = 0;

  always #5 clk16x = ~clk16x;

  manchester_frame_encoder dut (
    .clk16x(clk16x), .reset(reset), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready), .tx(tx), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );

  manchester_frame_encoder #(
    .DATA_W(12), .HALF_BIT_LEN(4), .SYNC_HALF_BITS(3),
    .POLARITY(1'b1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)
  ) dut2 (
    .clk16x(clk16x), .reset(reset), .s_valid(v2), .s_data(d2),
    .s_last(l2), .s_ready(rdy2), .tx(tx2), .busy(busy2),
    .frame_done(fd2), .underrun(un2)
  );

  always @(negedge clk16x) begin
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    if (underrun === 1'b1) un_cnt <= un_cnt + 1;
    if (fd2 === 1'b1) fd2_cnt <= fd2_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk16x);
    #1;
  endtask

  task automatic run_level(input string tag, input int which, input logic lvl, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (((which == 0) ? tx : tx2) !== lvl) bad++;
      step();
    end
    check(tag, bad, 0);
  endtask

  task automatic run_halves(input string tag, input int which, input logic [31:0] seq,
                            input int nh, input int hlen);
    int bad = 0;
    for (int h = 0; h < nh; h++) begin
      for (int c = 0; c < hlen; c++) begin
        if (((which == 0) ? tx : tx2) !== seq[nh-1-h]) bad++;
        step();
      end
    end
    check(tag, bad, 0);
  endtask

  // One A5 frame on the default build, checked cycle by cycle.
  task automatic a5_frame();
    int fd0 = fd_cnt;
    check("a5_ready_before", s_ready, 1);
    s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b1;
    step();
    s_valid = 1'b0;
    check("a5_ready_after_accept", s_ready, 0);
    check("a5_busy_e0", busy, 0);
    check("a5_tx_e0", tx, 0);
    step();
    check("a5_busy_e1", busy, 1);
    check("a5_tx_e1", tx, 0);
    step();
    run_level("a5_sync_a", 0, 1'b1, 120);
    run_level("a5_sync_b", 0, 1'b0, 120);
    run_halves("a5_data", 0, 32'h0000_6699, 16, 40);
    check("a5_tx_idle", tx, 0);
    check("a5_busy_end", busy, 0);
    check("a5_frame_done_low", frame_done, 0);
    check("a5_frame_done_count", fd_cnt - fd0, 1);
  endtask

  // Feed nwords words as fast as s_ready allows; return at the sample where busy drops.
  task automatic run_frame(input int nwords, input logic [3:0] last_mask,
                           output int busy_cycles, output int taken);
    logic [7:0] words [4];
    logic rdy;
    bit seen;
    words = '{8'h3C, 8'hC3, 8'h5A, 8'h96};
    taken = 0; busy_cycles = 0; seen = 1'b0;
    s_valid = 1'b1; s_data = words[0]; s_last = last_mask[0];
    for (int c = 0; c < 4000; c++) begin
      rdy = s_ready;
      if (busy) begin
        seen = 1'b1;
        busy_cycles++;
      end else if (seen) begin
        break;
      end
      step();
      if (s_valid && rdy) begin
        taken++;
        check("hold_ready_low", s_ready, 0);
        if (taken < nwords) begin
          s_data = words[taken];
          s_last = last_mask[taken];
        end else begin
          s_valid = 1'b0;
        end
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    int fd0, un0, fd20, bc, tk;
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    v2 = 1'b0; d2 = '0; l2 = 1'b0;
    repeat (3) step();
    check("rst_tx", tx, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_ready", s_ready, 0);
    check("rst_tx2_idle_high", tx2, 1);
    reset = 1'b0;
    step();
    check("post_rst_ready", s_ready, 1);
    check("post_rst_ready2", rdy2, 1);

    // Single-word frame with defaults.
    a5_frame();

    // Three-word frame, contiguous.
    fd0 = fd_cnt; un0 = un_cnt;
    run_frame(3, 4'b0100, bc, tk);
    check("three_busy_cycles", bc, 2160);
    check("three_words_taken", tk, 3);
    check("three_frame_done_pulse", frame_done, 1);
    step();
    check("three_tx_idle", tx, 0);
    check("three_fd_count", fd_cnt - fd0, 1);
    check("three_un_count", un_cnt - un0, 0);

    // Starved second word: truncated after word one.
    fd0 = fd_cnt; un0 = un_cnt;
    run_frame(1, 4'b0000, bc, tk);
    check("starve_busy_cycles", bc, 880);
    check("starve_underrun_pulse", underrun, 1);
    check("starve_no_frame_done", frame_done, 0);
    step();
    check("starve_tx_idle", tx, 0);
    check("starve_underrun_low", underrun, 0);
    check("starve_un_count", un_cnt - un0, 1);
    check("starve_fd_count", fd_cnt - fd0, 0);

    // Thomas, MSB first, 12-bit, idle high.
    fd20 = fd2_cnt;
    v2 = 1'b1; d2 = 12'h801; l2 = 1'b1;
    step();
    v2 = 1'b0;
    step();
    check("t12_tx_e1", tx2, 1);
    check("t12_busy_e1", busy2, 1);
    step();
    run_level("t12_sync_a", 1, 1'b0, 12);
    run_level("t12_sync_b", 1, 1'b1, 12);
    run_halves("t12_data", 1, 32'h0095_5556, 24, 4);
    check("t12_tx_idle", tx2, 1);
    check("t12_busy_end", busy2, 0);
    check("t12_fd_count", fd2_cnt - fd20, 1);

    // Reset in the middle of DATA with a second word buffered.
    s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b1;
    step();
    s_valid = 1'b0;
    repeat (300) step();
    check("mid_busy", busy, 1);
    check("mid_ready", s_ready, 1);
    s_valid = 1'b1; s_data = 8'h00; s_last = 1'b1;
    step();
    s_valid = 1'b0;
    reset = 1'b1;
    step();
    check("mid_rst_tx", tx, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", s_ready, 0);
    reset = 1'b0;
    step();
    check("mid_rel_ready", s_ready, 1);
    repeat (5) step();
    check("mid_buffer_dropped", busy, 0);
    a5_frame();

    // Back-to-back frames: next frame's word taken during the last word.
    fd0 = fd_cnt;
    run_frame(2, 4'b0011, bc, tk);
    check("b2b_first_busy", bc, 880);
    check("b2b_taken", tk, 2);
    check("b2b_frame_done_pulse", frame_done, 1);
    step();
    check("b2b_idle_gap_busy", busy, 1);
    check("b2b_idle_gap_tx", tx, 0);
    step();
    run_level("b2b_sync_a", 0, 1'b1, 120);
    run_level("b2b_sync_b", 0, 1'b0, 120);
    run_halves("b2b_data", 0, 32'h0000_5AA5, 16, 40);
    check("b2b_tx_idle", tx, 0);
    check("b2b_busy_end", busy, 0);
    check("b2b_fd_count", fd_cnt - fd0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
